// File: rtl/tdp_ram_param.sv
// tdp_ram_param: dual-port single-clock RAM with zeroize sweep, collision flag and optional output register (clk, rst, clear_req/busy, collision, port A/B en/we/addr/din -> dout/vld)
module tdp_ram_param #(
  parameter int    DATA_W         = 12,
  parameter int    DEPTH          = 256,
  parameter int    ADDR_W         = $clog2(DEPTH),
  parameter int    OUT_REG        = 0,
  parameter string WRITE_MODE     = "READ_FIRST",
  parameter int    CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              busy,
  output logic              collision,
  input  logic              en_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  output logic [DATA_W-1:0] dout_a,
  output logic              vld_a,
  input  logic              en_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] din_b,
  output logic [DATA_W-1:0] dout_b,
  output logic              vld_b
);
  localparam int HALF = DEPTH / 2;
  localparam bit WF = WRITE_MODE == "WRITE_FIRST";
  localparam bit NC = WRITE_MODE == "NO_CHANGE";
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, wr_addr_a, wr_addr_b;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_a, rd_b, dat_a, dat_b, wr_data_a, wr_data_b;
  logic [DATA_W-1:0] d1_a_q, d1_a_d, d1_b_q, d1_b_d;
  logic v1_a_q, v1_a_d, v1_b_q, v1_b_d, col_q, col_d;
  logic last, go, ea, eb, va, vb, same, wa, wb, wr_a, wr_b;
  assign busy = state_q == CLEAR;
  assign collision = col_q;
  always_comb begin
    last = cnt_q == ADDR_W'(HALF - 1);
    state_d = busy ? (last ? IDLE : CLEAR) : (clear_req ? CLEAR : IDLE);
    cnt_d = busy && !last ? cnt_q + 1'b1 : '0;
    go = state_d == IDLE;
    ea = en_a && !busy;
    eb = en_b && !busy;
    va = 32'(addr_a) < DEPTH;
    vb = 32'(addr_b) < DEPTH;
    same = addr_a == addr_b;
    wa = ea && we_a && va;
    wb = eb && we_b && vb && !(wa && same);
    wr_a = busy || wa;
    wr_b = busy || wb;
    wr_addr_a = busy ? ADDR_W'({cnt_q, 1'b0}) : addr_a;
    wr_addr_b = busy ? ADDR_W'({cnt_q, 1'b1}) : addr_b;
    wr_data_a = busy ? '0 : din_a;
    wr_data_b = busy ? '0 : din_b;
    rd_a = va ? mem[addr_a] : '0;
    rd_b = vb ? mem[addr_b] : '0;
    dat_a = we_a && WF ? din_a : rd_a;
    dat_b = we_b && WF ? din_b : rd_b;
    // go drops on the edge a sweep starts, so no read result leaks into the busy window
    v1_a_d = go && ea && !(we_a && NC);
    v1_b_d = go && eb && !(we_b && NC);
    d1_a_d = v1_a_d ? dat_a : d1_a_q;
    d1_b_d = v1_b_d ? dat_b : d1_b_q;
    col_d = go && ea && eb && va && same && (we_a || we_b);
  end
  always_ff @(posedge clk) begin
    if (wr_a) mem[wr_addr_a] <= wr_data_a;
    if (wr_b) mem[wr_addr_b] <= wr_data_b;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR_ON_RESET != 0 ? CLEAR : IDLE;
      cnt_q <= '0;
      col_q <= 1'b0;
      v1_a_q <= 1'b0;
      v1_b_q <= 1'b0;
      d1_a_q <= '0;
      d1_b_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      col_q <= col_d;
      v1_a_q <= v1_a_d;
      v1_b_q <= v1_b_d;
      d1_a_q <= d1_a_d;
      d1_b_q <= d1_b_d;
    end
  end
  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_W-1:0] d2_a_q, d2_a_d, d2_b_q, d2_b_d;
    logic v2_a_q, v2_a_d, v2_b_q, v2_b_d;
    always_comb begin
      v2_a_d = go && v1_a_q;
      v2_b_d = go && v1_b_q;
      d2_a_d = v2_a_d ? d1_a_q : d2_a_q;
      d2_b_d = v2_b_d ? d1_b_q : d2_b_q;
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v2_a_q <= 1'b0;
        v2_b_q <= 1'b0;
        d2_a_q <= '0;
        d2_b_q <= '0;
      end else begin
        v2_a_q <= v2_a_d;
        v2_b_q <= v2_b_d;
        d2_a_q <= d2_a_d;
        d2_b_q <= d2_b_d;
      end
    end
    assign vld_a = v2_a_q;
    assign vld_b = v2_b_q;
    assign dout_a = d2_a_q;
    assign dout_b = d2_b_q;
  end else begin : g_noreg
    assign vld_a = v1_a_q;
    assign vld_b = v1_b_q;
    assign dout_a = d1_a_q;
    assign dout_b = d1_b_q;
  end
endmodule
